fetch_queue: RTL and testbench

//   Parametrised instruction prefetch queue between Imem and Fetch. Decouples

---
 rtl/fetch_queue.sv | 107 ++++++++++
 tb/tb_fetch_queue.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO between Imem and Fetch. Requests are throttled by
// credits (queued + outstanding <= DEPTH); responses to requests issued before a redirect are dropped.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     redirectValid,
    input  logic [XLEN-1:0]          redirectAddress,
    output logic                     imemRequest,
    output logic [XLEN-1:0]          imemAddress,
    input  logic                     imemValid,
    input  logic [31:0]              imemData,
    output logic                     outValid,
    output logic [31:0]              outInstruction,
    output logic [XLEN-1:0]          outProgramCounter,
    input  logic                     outReady,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;

    logic [CW:0]     w_in_flight;
    logic            w_req;
    logic            w_pop;
    logic            w_resp_current;
    logic            w_push;
    logic            w_unused_addr_lsbs;

    // One bit wider than the counters so the credit sum cannot wrap.
    assign w_in_flight    = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_req          = !reset && !redirectValid && (w_in_flight < DEPTH_W);
    assign w_pop          = outValid && outReady;
    assign w_resp_current = imemValid && (r_drop == '0);
    assign w_push         = w_resp_current && !redirectValid && !reset;

    assign w_unused_addr_lsbs = ^redirectAddress[1:0];

    assign imemRequest       = w_req;
    assign imemAddress       = r_fetch_pc;
    assign count             = r_count;
    assign outValid          = (r_count != '0);
    assign outInstruction    = outValid ? r_mem[r_rd_ptr].instr : '0;
    assign outProgramCounter = outValid ? r_mem[r_rd_ptr].pc    : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
        end else if (redirectValid) begin
            // Every request still in flight becomes stale; a response landing now
            // retires one of them whether it was counted as outstanding or as drop.
            r_rd_ptr      <= r_wr_ptr;
            r_count       <= '0;
            r_fetch_pc    <= {redirectAddress[XLEN-1:2], 2'b00};
            r_resp_pc     <= {redirectAddress[XLEN-1:2], 2'b00};
            r_drop        <= r_drop + r_outstanding - CW'(imemValid);
            r_outstanding <= '0;
        end else begin
            if (w_req)
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                r_resp_pc <= r_resp_pc + XLEN'(4);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (imemValid && (r_drop != '0))
                r_drop <= r_drop - 1'b1;
            r_count       <= r_count + CW'(w_push) - CW'(w_pop);
            r_outstanding <= r_outstanding + CW'(w_req) - CW'(w_resp_current);
        end
    end

    // NOTE: storage has no reset; outValid gates every read, so stale contents are never observed.
    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wr_ptr] <= '{instr: imemData, pc: r_resp_pc};
    end

    a_credit: assert property (@(posedge clock) disable iff (reset) w_in_flight <= DEPTH_W);
    a_drop:   assert property (@(posedge clock) disable iff (reset) {1'b0, r_drop} <= DEPTH_W);

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed checks of fetch_queue against a request/epoch
// reference model with an in-order fixed-latency Imem.
module tb_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clock           = 1'b0;
    logic        reset           = 1'b1;
    logic        redirectValid   = 1'b0;
    logic [31:0] redirectAddress = '0;
    logic        imemRequest;
    logic [31:0] imemAddress;
    logic        imemValid       = 1'b0;
    logic [31:0] imemData        = '0;
    logic        outValid;
    logic [31:0] outInstruction;
    logic [31:0] outProgramCounter;
    logic        outReady        = 1'b0;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_dut (
        .clock            (clock),
        .reset            (reset),
        .redirectValid    (redirectValid),
        .redirectAddress  (redirectAddress),
        .imemRequest      (imemRequest),
        .imemAddress      (imemAddress),
        .imemValid        (imemValid),
        .imemData         (imemData),
        .outValid         (outValid),
        .outInstruction   (outInstruction),
        .outProgramCounter(outProgramCounter),
        .outReady         (outReady),
        .count            (count)
    );

    always #5 clock = ~clock;

    // Reference model: queued entries, plus Imem requests tagged with the redirect epoch
    // in which they were issued. A response is kept only if its epoch is still current.
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;

    ent_t        m_q[$];
    req_t        imem_q[$];
    logic [31:0] m_fetch = RESET_PC;
    int          m_epoch = 0;
    int          cyc     = 0;
    int          lat     = 1;

    function automatic logic [31:0] img(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic int live_inflight();
        int n = 0;
        foreach (imem_q[i]) if (imem_q[i].epoch == m_epoch) n++;
        return n;
    endfunction

    function automatic bit e_req();
        return !reset && !redirectValid && (m_q.size() + live_inflight() < DEPTH);
    endfunction
    function automatic bit          e_valid(); return m_q.size() != 0; endfunction
    function automatic logic [31:0] e_instr(); return (m_q.size() != 0) ? m_q[0].instr : 32'h0; endfunction
    function automatic logic [31:0] e_pc();    return (m_q.size() != 0) ? m_q[0].pc : 32'h0; endfunction
    function automatic logic [2:0]  e_count(); return 3'(m_q.size()); endfunction

    // Advance one clock: update the model from the inputs present at the edge, then
    // drive the Imem response for the following cycle.
    task automatic step();
        bit   req, pop, keep;
        req_t r;
        ent_t e;
        req  = e_req();
        pop  = e_valid() && outReady;
        keep = 1'b0;
        @(posedge clock);
        if (reset) begin
            m_q.delete();
            imem_q.delete();
            m_fetch = RESET_PC;
            m_epoch++;
        end else begin
            if (imemValid && imem_q.size() > 0) begin
                r    = imem_q.pop_front();
                keep = !redirectValid && (r.epoch == m_epoch);
            end
            if (pop) m_q.delete(0);
            if (keep) begin
                e.instr = img(r.addr);
                e.pc    = r.addr;
                m_q.push_back(e);
            end
            if (redirectValid) begin
                m_q.delete();
                m_fetch = {redirectAddress[31:2], 2'b00};
                m_epoch++;
            end
            if (req) begin
                r.addr  = m_fetch;
                r.epoch = m_epoch;
                r.due   = cyc + lat;
                imem_q.push_back(r);
                m_fetch = m_fetch + 32'd4;
            end
        end
        cyc++;
        #1;
        if (imem_q.size() > 0 && imem_q[0].due <= cyc) begin
            imemValid = 1'b1;
            imemData  = img(imem_q[0].addr);
        end else begin
            imemValid = 1'b0;
            imemData  = $urandom;
        end
    endtask

    task automatic do_reset(input int latency);
        lat           = latency;
        reset         = 1'b1;
        redirectValid = 1'b0;
        outReady      = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        #1;
        if (outValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", outValid); end
        n_cmp++;
        if (outInstruction !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", outInstruction); end
        n_cmp++;
        if (outProgramCounter !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", outProgramCounter); end
        n_cmp++;
        if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++;
        if (imemRequest !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imemRequest); end
        n_cmp++;
        if (imemAddress !== RESET_PC) begin n_bad++; $display("FAIL reset_addr: got %h want %h", imemAddress, RESET_PC); end
        n_cmp++;
        reset = 1'b0;
        #1;
        if (imemRequest !== 1'b1) begin n_bad++; $display("FAIL reset_release_req: got %b want 1", imemRequest); end
        n_cmp++;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset(1);
        outReady = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (imemRequest !== 1'b1) begin n_bad++; $display("FAIL stream_req[%0d]: got %b want 1", k, imemRequest); end
            n_cmp++;
            if (k >= 2) begin
                exp_pc = 32'(4 * (k - 2));
                if (outValid !== 1'b1 || outProgramCounter !== exp_pc || outInstruction !== img(exp_pc)) begin
                    n_bad++;
                    $display("FAIL stream_head[%0d]: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                             k, outValid, outProgramCounter, outInstruction, exp_pc, img(exp_pc));
                end
                n_cmp++;
            end
            step();
        end
    endtask

    task automatic test_stall();
        int reqs;
        do_reset(1);
        reqs = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (imemRequest === 1'b1) reqs++;
            step();
        end
        #1;
        if (reqs !== 4) begin n_bad++; $display("FAIL stall_reqs: got %0d want 4", reqs); end
        n_cmp++;
        if (count !== 3'd4 || imemRequest !== 1'b0) begin
            n_bad++; $display("FAIL stall_full: got count=%0d req=%b want count=4 req=0", count, imemRequest);
        end
        n_cmp++;
        outReady = 1'b1;
        #1;
        step();
        outReady = 1'b0;
        reqs = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (imemRequest === 1'b1) reqs++;
            step();
        end
        #1;
        if (reqs !== 1) begin n_bad++; $display("FAIL stall_pulse_reqs: got %0d want 1", reqs); end
        n_cmp++;
        if (count !== 3'd4 || outProgramCounter !== 32'h4) begin
            n_bad++; $display("FAIL stall_pulse_head: got count=%0d pc=%h want count=4 pc=4", count, outProgramCounter);
        end
        n_cmp++;
    endtask

    task automatic test_redirect_drop();
        int seen;
        do_reset(3);
        outReady = 1'b1;
        #1; step();
        #1; step();
        redirectValid   = 1'b1;
        redirectAddress = 32'h100;
        #1;
        if (imemRequest !== 1'b0) begin n_bad++; $display("FAIL redir_no_req: got %b want 0", imemRequest); end
        n_cmp++;
        step();
        redirectValid = 1'b0;
        #1;
        if (imemRequest !== 1'b1 || imemAddress !== 32'h100) begin
            n_bad++; $display("FAIL redir_first_req: got req=%b addr=%h want req=1 addr=100", imemRequest, imemAddress);
        end
        n_cmp++;
        seen = 0;
        for (int k = 0; k < 20 && seen < 2; k++) begin
            if (outValid === 1'b1) begin
                if (outProgramCounter !== 32'h100 + 32'(4 * seen) || outInstruction !== img(32'h100 + 32'(4 * seen))) begin
                    n_bad++;
                    $display("FAIL redir_head[%0d]: got pc=%h ins=%h want pc=%h", seen, outProgramCounter,
                             outInstruction, 32'h100 + 32'(4 * seen));
                end
                n_cmp++;
                seen++;
            end
            step();
            #1;
        end
        if (seen < 2) begin n_bad++; $display("FAIL redir_timeout: got %0d heads want 2", seen); end
        n_cmp++;
    endtask

    task automatic test_redirect_align();
        do_reset(1);
        outReady = 1'b1;
        for (int k = 0; k < 3; k++) begin #1; step(); end
        redirectValid   = 1'b1;
        redirectAddress = 32'h103;
        #1;
        step();
        redirectValid = 1'b0;
        #1;
        if (imemAddress !== 32'h100) begin n_bad++; $display("FAIL align_addr: got %h want 100", imemAddress); end
        n_cmp++;
        if (outValid !== 1'b0) begin n_bad++; $display("FAIL align_flush: got %b want 0", outValid); end
        n_cmp++;
    endtask

    task automatic test_full_wrap();
        int n;
        do_reset(1);
        for (int k = 0; k < 8; k++) begin #1; step(); end
        outReady = 1'b1;
        n = 0;
        for (int k = 0; k < 80 && n < 12; k++) begin
            #1;
            if (count !== e_count()) begin n_bad++; $display("FAIL wrap_count[%0d]: got %0d want %0d", k, count, e_count()); end
            n_cmp++;
            if (outValid === 1'b1) begin
                if (outProgramCounter !== 32'(4 * n) || outInstruction !== img(32'(4 * n))) begin
                    n_bad++;
                    $display("FAIL wrap_entry[%0d]: got pc=%h ins=%h want pc=%h ins=%h", n, outProgramCounter,
                             outInstruction, 32'(4 * n), img(32'(4 * n)));
                end
                n_cmp++;
                n++;
            end
            step();
        end
        if (n < 12) begin n_bad++; $display("FAIL wrap_timeout: got %0d entries want 12", n); end
        n_cmp++;
    endtask

    task automatic test_reset_midflight();
        bit got;
        do_reset(3);
        for (int k = 0; k < 3; k++) begin #1; step(); end
        reset = 1'b1;
        #1;
        if (imemRequest !== 1'b0) begin n_bad++; $display("FAIL midreset_req: got %b want 0", imemRequest); end
        n_cmp++;
        step();
        #1;
        if (outValid !== 1'b0 || outInstruction !== 32'h0 || outProgramCounter !== 32'h0 || count !== 3'd0 ||
            imemAddress !== RESET_PC) begin
            n_bad++;
            $display("FAIL midreset_state: got v=%b ins=%h pc=%h cnt=%0d addr=%h want all 0, addr=%h",
                     outValid, outInstruction, outProgramCounter, count, imemAddress, RESET_PC);
        end
        n_cmp++;
        reset    = 1'b0;
        outReady = 1'b1;
        got      = 1'b0;
        for (int k = 0; k < 15 && !got; k++) begin
            #1;
            if (outValid === 1'b1) begin
                got = 1'b1;
                if (outProgramCounter !== RESET_PC || outInstruction !== img(RESET_PC)) begin
                    n_bad++; $display("FAIL midreset_restart: got pc=%h ins=%h want pc=%h", outProgramCounter,
                                      outInstruction, RESET_PC);
                end
                n_cmp++;
            end
            step();
        end
        if (!got) begin n_bad++; $display("FAIL midreset_timeout: no entry after restart"); end
        n_cmp++;
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 4; seg++) begin
            do_reset(int'($urandom_range(3, 1)));
            for (int k = 0; k < 150; k++) begin
                outReady        = ($urandom_range(99) < 70);
                redirectValid   = ($urandom_range(99) < 12);
                redirectAddress = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
                #1;
                if (imemRequest !== e_req()) begin n_bad++; $display("FAIL rand_req[%0d]: got %b want %b", cyc, imemRequest, e_req()); end
                n_cmp++;
                if (imemAddress !== m_fetch) begin n_bad++; $display("FAIL rand_addr[%0d]: got %h want %h", cyc, imemAddress, m_fetch); end
                n_cmp++;
                if (outValid !== e_valid()) begin n_bad++; $display("FAIL rand_valid[%0d]: got %b want %b", cyc, outValid, e_valid()); end
                n_cmp++;
                if (outInstruction !== e_instr()) begin n_bad++; $display("FAIL rand_instr[%0d]: got %h want %h", cyc, outInstruction, e_instr()); end
                n_cmp++;
                if (outProgramCounter !== e_pc()) begin n_bad++; $display("FAIL rand_pc[%0d]: got %h want %h", cyc, outProgramCounter, e_pc()); end
                n_cmp++;
                if (count !== e_count()) begin n_bad++; $display("FAIL rand_count[%0d]: got %0d want %0d", cyc, count, e_count()); end
                n_cmp++;
                step();
            end
            redirectValid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_align();
        test_full_wrap();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
